// File: rtl/uart_host_bridge.sv
// uart_host_bridge: autonomous WISHBONE master moving bytes between CPU-side FIFOs and MiniUART.
module uart_host_fifo #(
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [7:0]    data_i,
   input  logic          push_i,
   input  logic          pop_i,
   output logic [7:0]    head_o,
   output logic [AW:0]   count_o
);
   localparam int N = 1 << AW;
   logic [7:0]    mem_q [N];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   count_q;
   logic          push_ok, pop_ok;
   // push when full is dropped even if a pop coincides; pop when empty is dropped
   assign push_ok = push_i && count_q != (AW+1)'(N);
   assign pop_ok  = pop_i && count_q != '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok) rd_q <= rd_q + 1'b1;
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end
   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

module uart_host_bridge #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic [7:0]            tx_byte,
   input  logic                  tx_push,
   output logic                  tx_full,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic [7:0]            rx_byte,
   input  logic                  rx_pop,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic                  rx_overrun,
   input  logic                  ovr_clr,
   output logic [5:2]            ADD_O,
   output logic [31:0]           DAT_O,
   input  logic [31:0]           DAT_I,
   output logic                  STB_O,
   output logic                  WE_O,
   input  logic                  ACK_I
);
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
   typedef enum logic [2:0] {POLL, RX_RD, RX_CLR, TX_WR, TX_HOLD} state_e;
   state_e     state_q, state_d;
   logic [1:0] hold_q, hold_d;
   logic       ovr_q, ovr_d, ovr_set;
   logic       rx_push, tx_pop, rx_full, tx_empty;
   logic [7:0] tx_head;
   logic       unused_dat;
   assign unused_dat = ^{DAT_I[31:8], DAT_I[4:1]};
   uart_host_fifo #(.AW(DEPTH_LOG2)) u_tx (
      .clk_i(CLK_I), .rst_i(RST_I), .data_i(tx_byte), .push_i(tx_push),
      .pop_i(tx_pop), .head_o(tx_head), .count_o(tx_count)
   );
   uart_host_fifo #(.AW(DEPTH_LOG2)) u_rx (
      .clk_i(CLK_I), .rst_i(RST_I), .data_i(DAT_I[7:0]), .push_i(rx_push),
      .pop_i(rx_pop), .head_o(rx_byte), .count_o(rx_count)
   );
   assign tx_full  = tx_count == FULL;
   assign tx_empty = tx_count == '0;
   assign rx_full  = rx_count == FULL;
   assign rx_empty = rx_count == '0;
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= POLL;
         hold_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         ovr_q   <= ovr_d;
      end
   end
   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      rx_push = 1'b0;
      tx_pop  = 1'b0;
      ovr_set = 1'b0;
      case (state_q)
         POLL: if (ACK_I) begin
            if (DAT_I[0]) begin
               state_d = rx_full ? RX_CLR : RX_RD;
               ovr_set = rx_full;
            end else if (DAT_I[5] && !tx_empty) state_d = TX_WR;
         end
         RX_RD: if (ACK_I) begin
            rx_push = 1'b1;
            state_d = RX_CLR;
         end
         RX_CLR: if (ACK_I) state_d = POLL;
         TX_WR: if (ACK_I) begin
            tx_pop  = 1'b1;
            state_d = TX_HOLD;
         end
         // quiet gap so MiniUART's registered tx load lands before ts is re-read
         TX_HOLD: begin
            hold_d  = hold_q == 2'd2 ? 2'd0 : hold_q + 1'b1;
            state_d = hold_q == 2'd2 ? POLL : TX_HOLD;
         end
         default: state_d = POLL;
      endcase
      ovr_d = ovr_set || (ovr_q && !ovr_clr);
   end
   assign rx_overrun = ovr_q;
   assign STB_O = !RST_I && state_q != TX_HOLD;
   assign WE_O  = !RST_I && (state_q == RX_CLR || state_q == TX_WR);
   assign ADD_O = RST_I ? 4'b0000 : state_q == POLL ? 4'b1000 :
                  (state_q == RX_RD || state_q == TX_WR) ? 4'b0100 : 4'b0000;
   assign DAT_O = (!RST_I && state_q == TX_WR) ? {24'b0, tx_head} : 32'b0;
endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge: directed bench with a small MiniUART register model answering the bridge's bus cycles.
module tb_uart_host_bridge;
   logic        CLK_I = 1'b0, RST_I = 1'b1;
   logic [7:0]  tx_byte = 8'h00;
   logic        tx_push = 1'b0, rx_pop = 1'b0, ovr_clr = 1'b0;
   logic        tx_full, rx_empty, rx_overrun, STB_O, WE_O, ACK_I;
   logic [4:0]  tx_count, rx_count;
   logic [7:0]  rx_byte;
   logic [5:2]  ADD_O;
   logic [31:0] DAT_O, DAT_I;
   logic        ts = 1'b0, rs = 1'b0, rs_req = 1'b0, stall = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   int          checks = 0, failures = 0, cyc = 0, rd_n = 0, clr_n = 0, wr_n = 0, rd_cyc = 0;
   logic [7:0]  wr_dat[$];
   int          wr_at[$];

   uart_host_bridge #(.DEPTH_LOG2(4)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .tx_byte(tx_byte), .tx_push(tx_push), .tx_full(tx_full),
      .tx_count(tx_count), .rx_byte(rx_byte), .rx_pop(rx_pop), .rx_empty(rx_empty),
      .rx_count(rx_count), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr), .ADD_O(ADD_O),
      .DAT_O(DAT_O), .DAT_I(DAT_I), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
   );

   always #5 CLK_I = ~CLK_I;

   // the UART acks at once unless stalling its tx-data write
   assign ACK_I = STB_O && !(stall && WE_O && ADD_O == 4'b0100);
   assign DAT_I = ADD_O == 4'b1000 ? {26'b0, ts, 4'b0, rs} :
                  ADD_O == 4'b0100 ? {24'b0, rx_data} : 32'b0;

   always @(posedge CLK_I) begin
      cyc <= cyc + 1;
      if (rs_req) rs <= 1'b1;
      else if (STB_O && ACK_I && WE_O) rs <= 1'b0;
      if (STB_O && ACK_I && !WE_O && ADD_O == 4'b0100) begin
         rd_n   <= rd_n + 1;
         rd_cyc <= cyc;
      end
      if (STB_O && ACK_I && WE_O && ADD_O == 4'b0000) clr_n <= clr_n + 1;
      if (STB_O && ACK_I && WE_O && ADD_O == 4'b0100) begin
         wr_n <= wr_n + 1;
         wr_dat.push_back(DAT_O[7:0]);
         wr_at.push_back(cyc);
      end
   end

   task automatic deliver(input logic [7:0] d, output bit ok);
      int c0;
      c0 = clr_n;
      rx_data = d;
      rs_req = 1'b1;
      @(negedge CLK_I);
      rs_req = 1'b0;
      for (int i = 0; i < 30 && clr_n == c0; i++) @(negedge CLK_I);
      ok = clr_n != c0;
   endtask

   task automatic test_reset;
      RST_I = 1'b1;
      repeat (3) @(negedge CLK_I);
      checks++; if ({STB_O, WE_O, ADD_O, DAT_O} !== 38'b0) begin failures++; $display("FAIL reset_bus got=%0h exp=0", {STB_O, WE_O, ADD_O, DAT_O}); end
      checks++; if ({tx_full, tx_count, rx_empty, rx_count, rx_byte, rx_overrun} !== {1'b0, 5'd0, 1'b1, 5'd0, 8'd0, 1'b0}) begin failures++; $display("FAIL reset_fifo got=%0h exp=%0h", {tx_full, tx_count, rx_empty, rx_count, rx_byte, rx_overrun}, {1'b0, 5'd0, 1'b1, 5'd0, 8'd0, 1'b0}); end
      RST_I = 1'b0;
      #1;
      checks++; if ({STB_O, WE_O, ADD_O} !== 6'b101000) begin failures++; $display("FAIL first_poll got=%0b exp=101000", {STB_O, WE_O, ADD_O}); end
      @(negedge CLK_I);
   endtask

   task automatic test_tx;
      int w0;
      w0 = wr_n;
      ts = 1'b1;
      tx_byte = 8'h55; tx_push = 1'b1;
      @(negedge CLK_I);
      tx_byte = 8'hA3;
      checks++; if (tx_count !== 5'd1) begin failures++; $display("FAIL tx_count_push got=%0d exp=1", tx_count); end
      @(negedge CLK_I);
      tx_push = 1'b0;
      for (int i = 0; i < 60 && wr_n < w0 + 2; i++) @(negedge CLK_I);
      checks++; if (wr_n !== w0 + 2) begin failures++; $display("FAIL tx_writes got=%0d exp=%0d", wr_n - w0, 2); end
      checks++; if (wr_dat[w0] !== 8'h55) begin failures++; $display("FAIL tx_dat0 got=%0h exp=55", wr_dat[w0]); end
      checks++; if (wr_dat[w0+1] !== 8'hA3) begin failures++; $display("FAIL tx_dat1 got=%0h exp=a3", wr_dat[w0+1]); end
      checks++; if (wr_at[w0+1] - wr_at[w0] !== 5) begin failures++; $display("FAIL tx_gap got=%0d exp=5", wr_at[w0+1] - wr_at[w0]); end
      checks++; if (tx_count !== 5'd0) begin failures++; $display("FAIL tx_drain got=%0d exp=0", tx_count); end
      repeat (4) @(negedge CLK_I);
   endtask

   task automatic test_rx;
      int r0;
      bit ok;
      ts = 1'b0;
      r0 = rd_n;
      deliver(8'h3C, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rx_clr got=0 exp=1"); end
      checks++; if (rd_n !== r0 + 1) begin failures++; $display("FAIL rx_reads got=%0d exp=1", rd_n - r0); end
      checks++; if ({rx_byte, rx_count, rx_empty} !== {8'h3C, 5'd1, 1'b0}) begin failures++; $display("FAIL rx_head got=%0h exp=%0h", {rx_byte, rx_count, rx_empty}, {8'h3C, 5'd1, 1'b0}); end
      rx_pop = 1'b1;
      @(negedge CLK_I);
      rx_pop = 1'b0;
      checks++; if ({rx_empty, rx_count} !== {1'b1, 5'd0}) begin failures++; $display("FAIL rx_pop got=%0h exp=%0h", {rx_empty, rx_count}, {1'b1, 5'd0}); end
   endtask

   task automatic test_priority;
      int r0, w0;
      r0 = rd_n; w0 = wr_n;
      ts = 1'b1;
      tx_byte = 8'h77; tx_push = 1'b1;
      rx_data = 8'h91; rs_req = 1'b1;
      @(negedge CLK_I);
      tx_push = 1'b0; rs_req = 1'b0;
      for (int i = 0; i < 40 && wr_n == w0; i++) @(negedge CLK_I);
      checks++; if (rd_n !== r0 + 1) begin failures++; $display("FAIL prio_reads got=%0d exp=1", rd_n - r0); end
      checks++; if (!(wr_n == w0 + 1 && rd_cyc < wr_at[w0])) begin failures++; $display("FAIL prio_order got=rd@%0d wr@%0d exp=rd_first", rd_cyc, wr_at[w0]); end
      checks++; if (wr_dat[w0] !== 8'h77) begin failures++; $display("FAIL prio_tx got=%0h exp=77", wr_dat[w0]); end
      checks++; if (rx_byte !== 8'h91) begin failures++; $display("FAIL prio_rx got=%0h exp=91", rx_byte); end
      rx_pop = 1'b1;
      @(negedge CLK_I);
      rx_pop = 1'b0; ts = 1'b0;
      repeat (4) @(negedge CLK_I);
   endtask

   task automatic test_overrun;
      int r0, bad;
      bit ok;
      bad = 0;
      ts = 1'b0;
      for (int i = 0; i < 16; i++) begin
         deliver(8'h10 + 8'(i), ok);
         if (!ok) bad++;
      end
      checks++; if (bad !== 0 || rx_count !== 5'd16) begin failures++; $display("FAIL ovr_fill got=%0d timeouts=%0d exp=16", rx_count, bad); end
      r0 = rd_n;
      deliver(8'hEE, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ovr_clr_write got=0 exp=1"); end
      checks++; if (rd_n !== r0) begin failures++; $display("FAIL ovr_noread got=%0d exp=0", rd_n - r0); end
      checks++; if ({rx_overrun, rx_count, rx_byte} !== {1'b1, 5'd16, 8'h10}) begin failures++; $display("FAIL ovr_state got=%0h exp=%0h", {rx_overrun, rx_count, rx_byte}, {1'b1, 5'd16, 8'h10}); end
      ovr_clr = 1'b1;
      @(negedge CLK_I);
      ovr_clr = 1'b0;
      checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared got=%0b exp=0", rx_overrun); end
      rx_pop = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (rx_byte !== 8'h10 + 8'(i)) begin failures++; $display("FAIL ovr_pop%0d got=%0h exp=%0h", i, rx_byte, 8'h10 + 8'(i)); end
         @(negedge CLK_I);
      end
      rx_pop = 1'b0;
      checks++; if ({rx_empty, rx_count} !== {1'b1, 5'd0}) begin failures++; $display("FAIL ovr_empty got=%0h exp=%0h", {rx_empty, rx_count}, {1'b1, 5'd0}); end
   endtask

   task automatic test_back_to_back;
      int w0;
      w0 = wr_n;
      ts = 1'b1; stall = 1'b1;
      tx_byte = 8'hC7; tx_push = 1'b1;
      @(negedge CLK_I);
      tx_push = 1'b0;
      for (int i = 0; i < 20 && !(WE_O && ADD_O == 4'b0100); i++) @(negedge CLK_I);
      for (int i = 0; i < 5; i++) begin
         checks++; if ({STB_O, WE_O, ADD_O, DAT_O, tx_count} !== {1'b1, 1'b1, 4'b0100, 32'hC7, 5'd1} || wr_n !== w0) begin failures++; $display("FAIL stall%0d got=%0h exp=%0h", i, {STB_O, WE_O, ADD_O, DAT_O, tx_count}, {1'b1, 1'b1, 4'b0100, 32'hC7, 5'd1}); end
         @(negedge CLK_I);
      end
      stall = 1'b0;
      tx_byte = 8'h5A; tx_push = 1'b1;
      @(negedge CLK_I);
      tx_push = 1'b0;
      checks++; if ({wr_n - w0, tx_count} !== {32'd1, 5'd1}) begin failures++; $display("FAIL push_pop got=writes %0d count %0d exp=writes 1 count 1", wr_n - w0, tx_count); end
      checks++; if (wr_dat[w0] !== 8'hC7) begin failures++; $display("FAIL stall_dat got=%0h exp=c7", wr_dat[w0]); end
      repeat (2) @(negedge CLK_I);
      checks++; if (wr_n !== w0 + 1) begin failures++; $display("FAIL single_pop got=%0d exp=1", wr_n - w0); end
      for (int i = 0; i < 20 && wr_n < w0 + 2; i++) @(negedge CLK_I);
      checks++; if (wr_dat[w0+1] !== 8'h5A || tx_count !== 5'd0) begin failures++; $display("FAIL b2b_second got=%0h/%0d exp=5a/0", wr_dat[w0+1], tx_count); end
      ts = 1'b0;
      repeat (4) @(negedge CLK_I);
   endtask

   task automatic test_reset_mid;
      tx_byte = 8'h11; tx_push = 1'b1;
      @(negedge CLK_I);
      tx_push = 1'b0;
      checks++; if (tx_count !== 5'd1) begin failures++; $display("FAIL mid_push got=%0d exp=1", tx_count); end
      RST_I = 1'b1;
      @(negedge CLK_I);
      checks++; if ({tx_count, STB_O} !== {5'd0, 1'b0}) begin failures++; $display("FAIL mid_reset got=%0h exp=0", {tx_count, STB_O}); end
      RST_I = 1'b0;
      @(negedge CLK_I);
   endtask

   initial begin
      test_reset();
      test_tx();
      test_rx();
      test_priority();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_host_bridge.md
# uart_host_bridge

Bus-master bridge between the CPU and the MiniUART register port. Buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO. Drives the MiniUART WISHBONE slave port autonomously: it polls the line status register, drains received bytes, and issues transmit writes. The CPU then exchanges bytes through simple push/pop handshakes and never touches UART registers directly.

## Interface
Parameters:
- DEPTH_LOG2, default 4: each FIFO holds 2^DEPTH_LOG2 bytes.

Ports:
- CLK_I  in  1  clock; the bridge uses one clock, shared with MiniUART.
- RST_I  in  1  reset, synchronous and active-high.
- tx_byte  in  8  byte to enqueue for transmission.
- tx_push  in  1  enqueue tx_byte this cycle.
- tx_full  out  1  TX FIFO full.
- tx_count  out  DEPTH_LOG2+1  TX FIFO occupancy.
- rx_byte  out  8  head of RX FIFO (show-ahead).
- rx_pop  in  1  dequeue RX head this cycle.
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy.
- rx_overrun  out  1  sticky; set when a received byte is dropped because the RX FIFO is full.
- ovr_clr  in  1  clears rx_overrun.
- ADD_O  out  [5:2]  UART register address.
- DAT_O  out  32  UART write data.
- DAT_I  in  32  UART read data.
- STB_O  out  1  bus strobe.
- WE_O  out  1  bus write enable.
- ACK_I  in  1  bus acknowledge.

## Operation
- UART register map used by the bridge:
  - 4'b0100: read gives rx data in [7:0]; write loads tx data.
  - 4'b1000: LSR; bit5 = TX idle (ts), bit0 = RX ready (rs).
  - Any bus write clears rs. Address 4'b0000 is used as a side-effect-free write for that purpose.
- Bus outputs are decoded from the state register only (Moore). A bus state advances only on ACK_I; with STB_O high and ACK_I low, the state and outputs hold.
- States:
  - POLL: ADD_O=4'b1000, STB_O=1, WE_O=0. On ACK_I:
    - DAT_I[0]=1 and RX not full → RX_RD.
    - DAT_I[0]=1 and RX full → RX_CLR, and rx_overrun set.
    - DAT_I[0]=0, DAT_I[5]=1, TX not empty → TX_WR.
    - Otherwise stay in POLL.
  - RX_RD: ADD_O=4'b0100, read. On ACK_I, push DAT_I[7:0] into the RX FIFO → RX_CLR.
  - RX_CLR: ADD_O=4'b0000, STB_O=1, WE_O=1, DAT_O=0. On ACK_I → POLL.
  - TX_WR: ADD_O=4'b0100, STB_O=1, WE_O=1, DAT_O={24'b0, TX head}. On ACK_I, pop TX → TX_HOLD.
  - TX_HOLD: STB_O=0 for exactly 3 cycles, counted by a 2-bit counter, then → POLL. This prevents re-reading a stale ts=1 before MiniUART's registered load takes effect.
- RX service has priority over TX whenever rs=1.
- FIFOs:
  - Circular buffers with DEPTH_LOG2-bit pointers that wrap modulo depth; occupancy counters are DEPTH_LOG2+1 bits.
  - A push when full is ignored (count unchanged). A pop when empty is ignored.
  - A simultaneous push and pop on the same FIFO is legal: count unchanged and both pointers advance. A pop when empty with a simultaneous push is treated as push-only.
  - An internal RX push from RX_RD and a CPU rx_pop may coincide; the same rule applies.
- rx_overrun: if a set and ovr_clr occur in the same cycle, set wins.
- Known limitation: a byte whose rs rises in the single cycle between the POLL sample and the TX_WR write is cleared by that write and lost. This is accepted.

## Timing
- Reset values:
  - State POLL, hold counter 0.
  - STB_O=0, WE_O=0, ADD_O=0, DAT_O=0 during reset.
  - tx_full=0, tx_count=0, rx_empty=1, rx_count=0, rx_byte=0 (storage cleared), rx_overrun=0.
- First STB_O=1 in the first cycle after RST_I deasserts.
- Reset mid-transaction abandons the transaction; FIFO contents are discarded.
- tx_push → tx_count and tx_full update next cycle.
- rx_pop → next head on rx_byte next cycle.
- With an immediate ACK_I:
  - RX byte: POLL → RX_RD → RX_CLR, 3 cycles; the byte is visible on rx_byte (rx_empty=0) the cycle after RX_RD.
  - TX byte: POLL → TX_WR → 3× TX_HOLD → POLL, 5 cycles per byte issue.
  - Idle POLL re-reads LSR every cycle.

## Test plan
- Reset hold with RST_I=1 for 3 cycles → all outputs at reset values, STB_O=0. After release, cycle 1: STB_O=1, ADD_O=4'b1000, WE_O=0.
- Push 0x55 and 0xA3 with ts=1 → two TX_WR writes, DAT_O=0x55 then 0xA3, separated by ≥4 cycles; tx_count returns to 0.
- Model UART asserting rs with rx data 0x3C → RX_RD read, then RX_CLR write to 4'b0000; rx_byte=0x3C, rx_count=1; rx_pop → rx_empty=1.
- rs=1 and ts=1 with TX non-empty → RX_RD taken before TX_WR.
- Fill RX with 16 bytes, then deliver a 17th → byte dropped, rx_overrun=1, rx_count=16, RX_CLR still issued. ovr_clr → rx_overrun=0.
- Hold ACK_I=0 for 5 cycles in TX_WR → outputs stable, no pop; after ACK_I the pop occurs exactly once. Also verify simultaneous tx_push and pop keeps the count.
